// File: rtl/fp16_opfifo_pkg.sv
// Shared types and sizing for the FP16 operand FIFO.
package fp16_opfifo_pkg;
  localparam int FP16_W        = 16;
  localparam int NUM_OPS       = 3;
  localparam int DEFAULT_DEPTH = 4;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH);
  localparam int CNT_W         = PTR_W + 1;

  typedef logic [NUM_OPS-1:0][FP16_W-1:0] operand_vec_t;
endpackage

// File: rtl/fp16_opfifo_ram.sv
// Operand storage: one register per entry, synchronous write, asynchronous read.
// Entry 0 is cleared on reset so the head reads zero while empty.
module fp16_opfifo_ram #(
  parameter int WIDTH        = 16,
  parameter int NUM_OPERANDS = 3,
  parameter int DEPTH        = 4,
  localparam int PW          = $clog2(DEPTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                we,
  input  logic [PW-1:0]                       waddr,
  input  logic [NUM_OPERANDS-1:0][WIDTH-1:0]  wdata,
  input  logic [PW-1:0]                       raddr,
  output logic [NUM_OPERANDS-1:0][WIDTH-1:0]  rdata
);
  logic [NUM_OPERANDS-1:0][WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] q;
    if (i == 0) begin : g_rst
      // Entry 0 is reset so the idle head presents zeros.
      always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)                      q <= '0;
        else if (we && waddr == PW'(i))   q <= wdata;
    end else begin : g_nrst
      // Remaining entries hold don't-care data until written.
      always_ff @(posedge clk_i)
        if (we && waddr == PW'(i))        q <= wdata;
    end
    assign mem[i] = q;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fp16_operand_fifo.sv
// Operand FIFO between a no-backpressure FP16 generator and the FPU input
// handshake. Reports sticky overflow and end-of-stream drain.
// Define FP16_OPFIFO_BYPASS_EN to let a word pass straight through an empty
// FIFO in the same cycle it arrives.
module fp16_operand_fifo
  import fp16_opfifo_pkg::*;
#(
  parameter int WIDTH        = FP16_W,
  parameter int NUM_OPERANDS = NUM_OPS,
  parameter int DEPTH        = DEFAULT_DEPTH,
  localparam int PW          = $clog2(DEPTH),
  localparam int CW          = PW + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               gen_valid_i,
  input  logic [NUM_OPERANDS-1:0][WIDTH-1:0] gen_operands_i,
  input  logic                               gen_end_i,
  output logic [NUM_OPERANDS-1:0][WIDTH-1:0] operands_o,
  output logic                               in_valid_o,
  input  logic                               in_ready_i,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [CW-1:0]                      count_o,
  output logic                               overflow_o,
  output logic                               drained_o
);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_n;
  logic          overflow_q, end_seen, drained_q, end_n;
  logic          push, pop, drop;
  logic [NUM_OPERANDS-1:0][WIDTH-1:0] rd_data;

  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == CW'(DEPTH));
  // pop only ever refers to a stored entry; a bypassed word never touches state
  assign pop     = !empty_o && in_ready_i;
  assign drop    = gen_valid_i && full_o && !pop;

`ifdef FP16_OPFIFO_BYPASS_EN
  logic bypass;
  assign bypass     = empty_o && gen_valid_i && in_ready_i;
  assign in_valid_o = !empty_o || gen_valid_i;
  assign operands_o = empty_o ? gen_operands_i : rd_data;
  assign push       = gen_valid_i && (!full_o || pop) && !bypass;
`else
  assign in_valid_o = !empty_o;
  assign operands_o = rd_data;
  assign push       = gen_valid_i && (!full_o || pop);
`endif

  fp16_opfifo_ram #(
    .WIDTH(WIDTH), .NUM_OPERANDS(NUM_OPERANDS), .DEPTH(DEPTH)
  ) u_ram (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (gen_operands_i),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Next occupancy and end flag, shared by the count and drained registers.
  always_comb begin
    cnt_n = cnt;
    case ({push, pop})
      2'b10:   cnt_n = cnt + CW'(1);
      2'b01:   cnt_n = cnt - CW'(1);
      default: cnt_n = cnt;
    endcase
    end_n = end_seen || gen_end_i;
  end

  // Pointers, occupancy and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow_q <= 1'b0;
      end_seen   <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt       <= cnt_n;
      if (drop) overflow_q <= 1'b1;
      end_seen  <= end_n;
      drained_q <= end_n && (cnt_n == '0);
    end
  end

  assign count_o    = cnt;
  assign overflow_o = overflow_q;
  assign drained_o  = drained_q;
endmodule

// File: tb/tb_fp16_operand_fifo.sv
// Scoreboard bench for fp16_operand_fifo: directed scenarios then random traffic.
module tb_fp16_operand_fifo;
  import fp16_opfifo_pkg::*;
  localparam int D = DEFAULT_DEPTH;
`ifdef FP16_OPFIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk_i = 1'b0, rst_ni = 1'b0;
  logic         gen_valid_i = 1'b0, gen_end_i = 1'b0, in_ready_i = 1'b0;
  operand_vec_t gen_operands_i = '0, operands_o;
  logic         in_valid_o, full_o, empty_o, overflow_o, drained_o;
  logic [CNT_W-1:0] count_o;

  fp16_operand_fifo dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .gen_valid_i(gen_valid_i),
    .gen_operands_i(gen_operands_i), .gen_end_i(gen_end_i),
    .operands_o(operands_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .drained_o(drained_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: expected output order plus occupancy and flags.
  operand_vec_t exp_q[$];
  int occ = 0, cur_occ = 0;
  bit ovf_m = 0, end_m = 0, drn_m = 0, cur_ovf = 0, cur_drn = 0;

  // Model: decide each incoming word's fate from the inputs about to be clocked.
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) begin
      exp_q.delete();
      occ = 0; ovf_m = 0; end_m = 0; drn_m = 0;
      cur_occ = 0; cur_ovf = 0; cur_drn = 0;
    end else begin
      bit pop_s;
      cur_occ = occ; cur_ovf = ovf_m; cur_drn = drn_m;
      pop_s = in_ready_i && occ > 0;
      if (gen_valid_i) begin
        if (BYP && occ == 0 && in_ready_i) exp_q.push_back(gen_operands_i);
        else if (occ < D || pop_s) begin
          exp_q.push_back(gen_operands_i);
          occ++;
        end else ovf_m = 1;
      end
      if (pop_s) occ--;
      end_m = end_m || gen_end_i;
      drn_m = end_m && occ == 0;
    end
  end

  // Monitor: compare flags every cycle and the head against the scoreboard.
  initial forever begin
    @(negedge clk_i); #1;
    if (rst_ni) begin
      chk("count", 64'(count_o), 64'(cur_occ));
      chk("empty", 64'(empty_o), 64'(cur_occ == 0));
      chk("full", 64'(full_o), 64'(cur_occ == D));
      chk("overflow", 64'(overflow_o), 64'(cur_ovf));
      chk("drained", 64'(drained_o), 64'(cur_drn));
      chk("in_valid", 64'(in_valid_o), 64'(cur_occ > 0 || (BYP && gen_valid_i)));
      if (in_valid_o) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 64'(1), 64'(0));
        else if (in_ready_i) chk("pop_data", 64'(operands_o), 64'(exp_q.pop_front()));
        else chk("head_hold", 64'(operands_o), 64'(exp_q[0]));
      end
    end
  end

  task automatic cyc(bit v, operand_vec_t w, bit r, bit e);
    @(posedge clk_i); #1;
    gen_valid_i = v; gen_operands_i = w; in_ready_i = r; gen_end_i = e;
  endtask

  function automatic operand_vec_t wd(int n);
    operand_vec_t t;
    for (int k = 0; k < NUM_OPS; k++) t[k] = 16'(16'h1000 * (k + 1) + n);
    return t;
  endfunction

  initial begin
    operand_vec_t one;
    one = '0;
    one[0] = 16'h3C00; one[1] = 16'h4000; one[2] = 16'h0000;
    #3;
    chk("rst_in_valid", 64'(in_valid_o), 64'(0));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_full", 64'(full_o), 64'(0));
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_overflow", 64'(overflow_o), 64'(0));
    chk("rst_drained", 64'(drained_o), 64'(0));
    chk("rst_operands", 64'(operands_o), 64'(0));
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // single word with ready high
    cyc(1, one, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);

    // backpressure fill, then full push+pop, then drain
    for (int i = 0; i < 4; i++) cyc(1, wd(i), 0, 0);
    cyc(0, '0, 0, 0);
    cyc(1, wd(4), 1, 0);
    cyc(0, '0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0);

    // overflow: fifth word dropped while stalled
    for (int i = 10; i < 15; i++) cyc(1, wd(i), 0, 0);
    cyc(0, '0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0);

    // drain: three buffered words, end pulse, then pops
    for (int i = 20; i < 23; i++) cyc(1, wd(i), 0, 0);
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0);

    // reset mid-operation with two entries and overflow set
    for (int i = 30; i < 32; i++) cyc(1, wd(i), 0, 0);
    cyc(0, '0, 0, 0);
    @(posedge clk_i); #1 rst_ni = 1'b0;
    #1;
    chk("midrst_empty", 64'(empty_o), 64'(1));
    chk("midrst_in_valid", 64'(in_valid_o), 64'(0));
    chk("midrst_overflow", 64'(overflow_o), 64'(0));
    chk("midrst_count", 64'(count_o), 64'(0));
    @(negedge clk_i);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    cyc(1, wd(40), 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);

    // random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) < 60, operand_vec_t'({$urandom, $urandom}),
          $urandom_range(0, 99) < ((i / 100) % 2 ? 30 : 70), 0);

    // final drain with a bounded wait
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(0, '0, 1, 0);
    chk("final_drain_left", 64'(exp_q.size()), 64'(0));
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp16_operand_fifo.md
# fp16_operand_fifo

Operand-buffering stage between the FP16 stimulus generator and the `fpnew_top` multiplier input port. It captures operand triples from a generator that has no backpressure (valid-only, one triple per cycle), stores them in a small circular FIFO, and presents them to the FPU through the `in_valid`/`in_ready` handshake. It also reports drops and end-of-stream drain, so the bench ends only after every issued triple has entered the FPU.

## Interface
- `WIDTH`, 16, operand width in bits (FP16).
- `NUM_OPERANDS`, 3, operands per transaction.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk_i  in  1  clock; all state updates on rising edge`
- `rst_ni  in  1  asynchronous active-low reset`
- `gen_valid_i  in  1  generator word valid; cannot be stalled`
- `gen_operands_i  in  NUM_OPERANDS×WIDTH  packed operand triple, [k] = operand k`
- `gen_end_i  in  1  generator end-of-stream; level or pulse`
- `operands_o  out  NUM_OPERANDS×WIDTH  head-of-FIFO triple to the FPU`
- `in_valid_o  out  1  head entry valid`
- `in_ready_i  in  1  FPU accepts the head entry`
- `full_o  out  1  count == DEPTH`
- `empty_o  out  1  count == 0`
- `count_o  out  $clog2(DEPTH)+1  occupancy`
- `overflow_o  out  1  sticky; at least one generator word dropped`
- `drained_o  out  1  end seen and FIFO empty`

## Operation
- Storage: `DEPTH` entries, plus write pointer and read pointer of `$clog2(DEPTH)` bits each. Both pointers wrap modulo `DEPTH`. The count register is separate.
- `push = gen_valid_i && (!full_o || pop)`. A push while full is accepted only if a pop happens in the same cycle.
- `pop = in_valid_o && in_ready_i`.
- `drop = gen_valid_i && full_o && !pop`.
- On a drop, the word is discarded and `overflow_o` sets to 1. It stays 1 until reset.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `in_valid_o = !empty_o`.
- `operands_o` equals the head entry. It holds its value while `in_valid_o && !in_ready_i` and must not change until the pop.
- End-of-stream: `end_seen` register sets on any cycle where `gen_end_i` is 1, and is sticky.
  - A `gen_valid_i` word arriving in the same cycle as `gen_end_i` is still pushed.
- `drained_o = end_seen && empty_o`, registered from the next-state values. It asserts in the cycle after the final pop, or in the cycle after `end_seen` sets if the FIFO is already empty.
- There is no state machine beyond the `end_seen` flag. Control state consists of the pointers, the count, `overflow_o` and `end_seen`.

## Timing
- Reset values:
  - `in_valid_o` = 0, `empty_o` = 1, `full_o` = 0, `count_o` = 0.
  - `overflow_o` = 0, `drained_o` = 0, `operands_o` = 0.
  - Pointers = 0, `end_seen` = 0.
  - Storage contents are don't-care, except entry 0, which is cleared.
- Reset asserted mid-operation immediately discards all entries and flags. After reset deassertion, the first valid push is stored at entry 0.
- Latency without bypass: a word pushed at edge N appears with `in_valid_o` = 1 after edge N. That is one cycle from `gen_valid_i` to `in_valid_o`.
- Throughput: one push and one pop per cycle. When `in_ready_i` is held high, occupancy stays at or below 1.
- Full with simultaneous push and pop: occupancy stays at `DEPTH`, no drop occurs, and the write pointer and read pointer both advance.
- Empty with push: there is no pop in that cycle, because `in_valid_o` = 0.

## Configuration
- `FP16_OPFIFO_BYPASS_EN` defined:
  - When the FIFO is empty and `gen_valid_i` = 1, `in_valid_o` = 1 combinationally and `operands_o` = `gen_operands_i` in the same cycle.
  - If `in_ready_i` = 1 in that cycle, the word passes straight through, is not stored, and count stays 0.
  - If `in_ready_i` = 0, the word is pushed normally.
  - `empty_o` still reflects the stored count only.
- `FP16_OPFIFO_BYPASS_EN` undefined: registered-only behaviour as described in Operation and Timing, with one-cycle latency.

## Structure
- Shared package `fp16_opfifo_pkg` holds:
  - `operand_vec_t`, the packed `[NUM_OPERANDS-1:0][WIDTH-1:0]` type.
  - Localparams `PTR_W = $clog2(DEPTH)` and `CNT_W = PTR_W+1`.
  - The default-depth constant.
- One sub-module, `fp16_opfifo_ram`: a `DEPTH`×(`NUM_OPERANDS`·`WIDTH`) register array with a synchronous write port and an asynchronous read port.
- Pointer, count and flag logic live in the top level.

## Test plan
- Single word: after reset, push triple {0x3C00, 0x4000, 0x0000} with `in_ready_i` = 1.
  - Required: `in_valid_o` = 1 one cycle later and `operands_o[0]` = 0x3C00, `operands_o[1]` = 0x4000.
  - Required: `count_o` returns to 0 and `overflow_o` = 0.
- Backpressure fill: hold `in_ready_i` = 0 and push 4 words A–D.
  - Required: `full_o` = 1 and `count_o` = 4.
  - Required: the head stays A and does not change while stalled.
  - Then release `in_ready_i`: pops occur in order A, B, C, D over 4 cycles.
- Overflow: with the FIFO full and `in_ready_i` = 0, push a 5th word E.
  - Required: E is dropped, `overflow_o` = 1 and stays sticky, and the pops that follow are still A–D.
- Full push+pop: with the FIFO full, assert `gen_valid_i` and `in_ready_i` together.
  - Required: `count_o` stays 4, `overflow_o` stays 0, and the new word appears after the existing 3 entries.
- Drain: 3 words buffered, `gen_end_i` pulses, and `in_ready_i` then pops one word per cycle.
  - Required: `drained_o` = 0 until the cycle after the 3rd pop, then 1.
- Reset mid-operation: with 2 entries stored and `overflow_o` = 1, assert `rst_ni` = 0.
  - Required: immediately `empty_o` = 1, `in_valid_o` = 0 and `overflow_o` = 0.
  - Required: after release, a new word is popped first.
  - With `FP16_OPFIFO_BYPASS_EN`, rerun the single-word case and require `in_valid_o` = 1 in the same cycle as the push.
